// File: rtl/adc_capture.sv
// adc_capture: simultaneous-sampling dual-channel ADC readout.
// One start_conv pulse launches a conversion: wait for adc_busy to fall,
// clock DATA_W bits out of both channels MSB first on a generated adc_sclk,
// then present both samples with a one-cycle data_valid strobe.
//
// Handshake: start_conv is a one-cycle request that is accepted only in IDLE
// (anywhere else it is dropped and flagged on err_overrun). data_valid is a
// one-cycle strobe with no ready/backpressure; data_a/data_b hold until the
// next completed capture or reset.
module adc_capture #(
  parameter int         DATA_W     = 12,
  parameter int         SCLK_HALF  = 2,
  parameter logic [7:0] T_CONV_MAX = 8'd200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_conv,
  input  logic              adc_busy,
  input  logic              adc_sdo_a,
  input  logic              adc_sdo_b,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              data_valid,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic [1:0]        dbg_state
);

  // Counter widths hold SCLK_HALF and DATA_W themselves without wrapping.
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        conv_cnt;
  logic [HW-1:0]     half_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sh_a, sh_b;
  logic              half_wrap, sclk_rise, timeout, overrun;

  assign dbg_state = state_q;

  // Next-state logic plus the single-cycle events that the datapath consumes.
  always_comb begin
    state_d   = state_q;
    half_wrap = (half_cnt == HALF_LAST);
    sclk_rise = 1'b0;
    timeout   = 1'b0;
    overrun   = start_conv && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_conv) state_d = CONV;
      end
      CONV: begin
        // adc_busy is not trusted for the first two counts (ADC assert latency).
        // Timeout is declared in the cycle the counter shows T_CONV_MAX.
        if ((conv_cnt >= 8'd2) && !adc_busy) begin
          state_d = SHIFT;
        end else if (conv_cnt == T_CONV_MAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // A low half ending is a rising sclk edge (sample); a high half ending
        // after the last bit closes the frame with sclk left high.
        if (half_wrap) begin
          if (!adc_sclk) begin
            sclk_rise = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Counters, shift registers and all registered outputs, driven from state_d
  // so each output already reflects the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_cnt    <= 8'd0;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b1;
      data_a      <= '0;
      data_b      <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      conv_cnt <= (state_q == CONV) ? conv_cnt + 8'd1 : 8'd0;

      if (state_q != SHIFT) begin
        half_cnt <= '0;
        bit_cnt  <= '0;
      end else if (half_wrap) begin
        half_cnt <= '0;
        if (sclk_rise) bit_cnt <= bit_cnt + BW'(1);
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end

      if (sclk_rise) begin
        sh_a <= {sh_a[DATA_W-2:0], adc_sdo_a};
        sh_b <= {sh_b[DATA_W-2:0], adc_sdo_b};
      end

      adc_cs_n <= (state_d != SHIFT);
      if (state_d != SHIFT)      adc_sclk <= 1'b1;
      else if (state_q != SHIFT) adc_sclk <= 1'b0;
      else if (half_wrap)        adc_sclk <= ~adc_sclk;

      data_valid <= (state_d == DONE);
      if (state_d == DONE) begin
        data_a <= sh_a;
        data_b <= sh_b;
      end

      busy        <= (state_d != IDLE);
      err_timeout <= timeout;
      err_overrun <= overrun;
    end
  end

endmodule
